// File: rtl/mac_package.sv
// Shared types and defaults for the MAC job scheduler and its round-robin arbiter.
package mac_package;
  localparam int MAC_SCHED_N_REQ = 4;
  localparam int MAC_LEN_W       = 16;

  typedef struct packed {
    logic [MAC_LEN_W-1:0] len;
    logic [4:0]           shift;
    logic                 simple_mul;
  } mac_job_t;

  typedef enum logic [1:0] {SCHED_IDLE, SCHED_START, SCHED_RUN} sched_state_t;
endpackage

// File: rtl/mac_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr, searching circularly.
module mac_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);
  int idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!gnt_valid && req[idx]) begin
        gnt[idx]  = 1'b1;
        gnt_idx   = IDX_W'(idx);
        gnt_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mac_job_scheduler.sv
// Shares one MAC engine between N_REQ requesters: round-robin accept, start pulse,
// wait for done or watchdog expiry, then report a one-cycle event to the owner.
module mac_job_scheduler
  import mac_package::*;
#(
  parameter int  N_REQ     = MAC_SCHED_N_REQ,
  parameter int  LEN_W     = MAC_LEN_W,
  parameter int  TIMEOUT_W = 20,
  localparam int JOB_W     = LEN_W + 6,
  localparam int IDX_W     = $clog2(N_REQ)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  logic [N_REQ-1:0][JOB_W-1:0] req_job_i,
  input  logic [TIMEOUT_W-1:0]        timeout_i,
  output logic                        mac_start_o,
  output logic [JOB_W-1:0]            mac_job_o,
  input  logic                        mac_done_i,
  output logic                        mac_abort_o,
  output logic [N_REQ-1:0]            evt_o,
  output logic [N_REQ-1:0]            err_o,
  output logic                        busy_o,
  output logic [IDX_W-1:0]            owner_o
);
  sched_state_t         state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [TIMEOUT_W-1:0] cnt;
  logic [N_REQ-1:0]     gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_valid;
  logic [IDX_W-1:0]     ptr_next;
  logic                 job_nonzero;
  logic                 expire;

  mac_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req       (req_valid_i),
    .rr_ptr    (rr_ptr),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Held low while reset/clear is active so no job is handshaked and then dropped.
  assign req_ready_o = (state == SCHED_IDLE && !rst_i && !clear_i) ? gnt : '0;

  assign ptr_next    = (gnt_idx == IDX_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
  assign job_nonzero = |req_job_i[gnt_idx][JOB_W-1:6];
  assign expire      = (timeout_i != '0) && (cnt == timeout_i - 1'b1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= SCHED_IDLE;
      rr_ptr      <= '0;
      cnt         <= '0;
      mac_start_o <= 1'b0;
      mac_job_o   <= '0;
      mac_abort_o <= 1'b0;
      evt_o       <= '0;
      err_o       <= '0;
      busy_o      <= 1'b0;
      owner_o     <= '0;
    end else if (clear_i) begin
      state       <= SCHED_IDLE;
      rr_ptr      <= '0;
      cnt         <= '0;
      mac_start_o <= 1'b0;
      mac_job_o   <= '0;
      mac_abort_o <= 1'b0;
      evt_o       <= '0;
      err_o       <= '0;
      busy_o      <= 1'b0;
      owner_o     <= '0;
    end else begin
      mac_start_o <= 1'b0;
      mac_abort_o <= 1'b0;
      evt_o       <= '0;
      err_o       <= '0;
      case (state)
        SCHED_IDLE: begin
          if (gnt_valid) begin
            mac_job_o <= req_job_i[gnt_idx];
            owner_o   <= gnt_idx;
            rr_ptr    <= ptr_next;
            if (job_nonzero) begin
              state       <= SCHED_START;
              mac_start_o <= 1'b1;
              busy_o      <= 1'b1;
            end else begin
              evt_o <= gnt;
            end
          end
        end
        SCHED_START: begin
          cnt   <= '0;
          state <= SCHED_RUN;
        end
        SCHED_RUN: begin
          // Saturate so a disabled watchdog never wraps into a false match later.
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (mac_done_i) begin
            evt_o[owner_o] <= 1'b1;
            state          <= SCHED_IDLE;
            busy_o         <= 1'b0;
          end else if (expire) begin
            err_o[owner_o] <= 1'b1;
            mac_abort_o    <= 1'b1;
            state          <= SCHED_IDLE;
            busy_o         <= 1'b0;
          end
        end
        default: begin
          state  <= SCHED_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mac_job_scheduler.sv
// Directed bench for mac_job_scheduler: single job, fairness, timeout, collision, zero length, reset.
module tb_mac_job_scheduler;
  import mac_package::*;
  localparam int N  = 4;
  localparam int LW = 16;
  localparam int TW = 20;
  localparam int JW = LW + 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clear = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0][JW-1:0] req_job = '0;
  logic [TW-1:0]     timeout = '0;
  logic              mac_start;
  logic [JW-1:0]     mac_job;
  logic              mac_done = 1'b0;
  logic              mac_abort;
  logic [N-1:0]      evt;
  logic [N-1:0]      err;
  logic              busy;
  logic [1:0]        owner;

  int n_chk = 0;
  int n_err = 0;

  mac_job_scheduler #(.N_REQ(N), .LEN_W(LW), .TIMEOUT_W(TW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_job_i   (req_job),
    .timeout_i   (timeout),
    .mac_start_o (mac_start),
    .mac_job_o   (mac_job),
    .mac_done_i  (mac_done),
    .mac_abort_o (mac_abort),
    .evt_o       (evt),
    .err_o       (err),
    .busy_o      (busy),
    .owner_o     (owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic logic [JW-1:0] mkjob(input int len, input int sh, input bit sm);
    mac_job_t j;
    j.len        = 16'(len);
    j.shift      = 5'(sh);
    j.simple_mul = sm;
    return j;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  int order[$];
  int exp_ord[6] = '{0, 1, 2, 3, 0, 1};
  int dcnt;
  int nevt;
  int early;
  int guard;

  initial begin
    // Reset state; ready must stay low under reset even with a valid request.
    req_valid = 4'b0001;
    #3;
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_outs", 32'({mac_start, mac_abort, busy, evt, err, owner}), 32'(0));
    chk("rst_job", 32'(mac_job), 32'(0));
    req_valid = '0;
    #4 rst = 1'b0;

    // Single job, requester 2, len 8
    tick(); req_valid = 4'b0100; req_job[2] = mkjob(8, 3, 1'b1);
    mid();  chk("s_ready", 32'(req_ready), 32'(4'b0100));
            chk("s_nostart", 32'(mac_start), 32'(0));
    tick(); req_valid = '0;
    mid();  chk("s_start", 32'(mac_start), 32'(1));
            chk("s_job", 32'(mac_job), 32'({16'd8, 5'd3, 1'b1}));
            chk("s_owner", 32'(owner), 32'(2));
            chk("s_busy", 32'(busy), 32'(1));
    tick(); mid(); chk("s_start1", 32'(mac_start), 32'(0));
    tick(); mid();
    tick(); mac_done = 1'b1; mid(); chk("s_evt_early", 32'(evt), 32'(0));
    tick(); mac_done = 1'b0; mid();
    chk("s_evt", 32'(evt), 32'(4'b0100));
    chk("s_idle", 32'(busy), 32'(0));
    tick(); mid(); chk("s_evt1", 32'(evt), 32'(0));

    // Soft clear returns rr_ptr to 0
    tick(); clear = 1'b1;
    tick(); clear = 1'b0;

    // Fairness: all valid, done 5 cycles after each start
    for (int i = 0; i < N; i++) req_job[i] = mkjob(3, i, 1'b0);
    dcnt = 0; nevt = 0; guard = 0;
    while (!(order.size() == 6 && nevt == 6) && guard < 200) begin
      guard++;
      tick();
      req_valid = (order.size() < 6) ? 4'hF : 4'h0;
      mac_done  = (dcnt == 1);
      if (dcnt > 0) dcnt--;
      mid();
      if (req_ready != '0) order.push_back(oh_idx(req_ready));
      if (mac_start) dcnt = 5;
      if (evt != '0) nevt++;
    end
    mac_done = 1'b0;
    chk("f_grants", 32'(order.size()), 32'(6));
    chk("f_evts", 32'(nevt), 32'(6));
    for (int i = 0; i < order.size() && i < 6; i++) chk("f_order", 32'(order[i]), 32'(exp_ord[i]));

    // Timeout, T=10: requester 3 (rr_ptr is 2, only 3 valid)
    timeout = 20'd10;
    tick(); req_valid = 4'b1000; req_job[3] = mkjob(5, 0, 1'b0);
    mid();  chk("t_ready", 32'(req_ready), 32'(4'b1000));
    tick(); req_valid = '0;
    mid();  chk("t_start", 32'(mac_start), 32'(1));
    early = 0;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 11) begin
        req_valid  = 4'b0010;
        req_job[1] = mkjob(4, 0, 1'b0);
      end
      mid();
      if (k < 11) early += int'(mac_abort) + int'(|err);
      else begin
        chk("t_abort", 32'(mac_abort), 32'(1));
        chk("t_err", 32'(err), 32'(4'b1000));
        chk("t_next_ready", 32'(req_ready), 32'(4'b0010));
      end
    end
    chk("t_early", 32'(early), 32'(0));
    tick(); req_valid = '0;
    mid();  chk("t_abort1", 32'({mac_abort, err}), 32'(0));
            chk("t_start2", 32'(mac_start), 32'(1));
            chk("t_owner2", 32'(owner), 32'(1));

    // Clear mid-job: no events, no abort
    tick(); mid();
    tick(); clear = 1'b1; mid();
    tick(); clear = 1'b0;
    mid();  chk("c_quiet", 32'({mac_abort, evt, err, busy}), 32'(0));
    tick(); mid(); chk("c_quiet1", 32'({mac_abort, evt, err}), 32'(0));

    // Collision, T=4: done lands on the expiry cycle
    timeout = 20'd4;
    tick(); req_valid = 4'b0001; req_job[0] = mkjob(9, 1, 1'b0);
    mid();  chk("x_ready", 32'(req_ready), 32'(4'b0001));
    tick(); req_valid = '0; mid();
    tick(); mid();
    tick(); mid();
    tick(); mid();
    tick(); mac_done = 1'b1; mid();
    tick(); mac_done = 1'b0; mid();
    chk("x_evt", 32'(evt), 32'(4'b0001));
    chk("x_noerr", 32'({mac_abort, err}), 32'(0));
    tick(); mid(); chk("x_noerr1", 32'({mac_abort, err}), 32'(0));

    // Zero length, requester 1 (rr_ptr is 1)
    timeout = '0;
    tick(); req_valid = 4'b0010; req_job[1] = mkjob(0, 2, 1'b1);
    mid();  chk("z_ready", 32'(req_ready), 32'(4'b0010));
    tick(); req_valid = '0;
    mid();  chk("z_evt", 32'(evt), 32'(4'b0010));
            chk("z_nostart", 32'({mac_start, busy}), 32'(0));
            chk("z_owner", 32'(owner), 32'(1));
    tick(); mid(); chk("z_quiet", 32'({mac_start, busy, evt}), 32'(0));

    // Async reset in RUN, requester 2 (rr_ptr is 2)
    tick(); req_valid = 4'b0100; req_job[2] = mkjob(7, 0, 1'b0);
    mid();
    tick(); req_valid = '0; mid();
    tick(); mid(); chk("r_busy", 32'(busy), 32'(1));
    tick(); req_valid = 4'b1000; mid();
    rst = 1'b1;
    #1;
    chk("r_outs", 32'({req_ready, mac_start, mac_abort, busy, evt, err, owner}), 32'(0));
    chk("r_job", 32'(mac_job), 32'(0));
    tick(); rst = 1'b0; req_valid = '0; mac_done = 1'b1;
    mid();  chk("r_noevt", 32'({evt, err, busy}), 32'(0));
    tick(); mac_done = 1'b0;
    mid();  chk("r_noevt1", 32'({evt, err, mac_abort}), 32'(0));
    tick(); req_valid = 4'b1001; req_job[0] = mkjob(2, 0, 1'b0); req_job[3] = mkjob(2, 0, 1'b0);
    mid();  chk("r_ptr0", 32'(req_ready), 32'(4'b0001));
    tick(); req_valid = '0;
    mid();  chk("r_start", 32'(mac_start), 32'(1));
            chk("r_owner", 32'(owner), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
